// File: rtl/game_pkg.sv
// game_pkg
// Shared constants and types for the playfield controller family.
//   UNDEFINED_POSITION : value driven on object_position when no spawn occurs
//   DH_TIME            : visible horizontal pixels
//   OBJECT_WIDTH       : enemy sprite width in pixels
//   SPAWN_LIMIT        : exclusive upper bound of legal enemy x positions
//   MOVE_*             : encodings of the renderer move command
//   game_state_t       : IDLE / PLAY / OVER
//   fold_position()    : maps an LFSR value onto a legal enemy x position
package game_pkg;

    localparam int UNDEFINED_POSITION = 1000;
    localparam int DH_TIME            = 640;
    localparam int OBJECT_WIDTH       = 50;
    localparam int SPAWN_LIMIT        = DH_TIME - OBJECT_WIDTH;

    localparam logic [1:0] MOVE_RIGHT = 2'd0;
    localparam logic [1:0] MOVE_LEFT  = 2'd1;
    localparam logic [1:0] MOVE_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

    // Low 10 LFSR bits span 0..1023; a single conditional subtract folds the
    // top part back so the sprite always fits fully on screen.
    function automatic logic [10:0] fold_position(input logic [15:0] lfsr);
        logic [10:0] p;
        p = {1'b0, lfsr[9:0]};
        if (p >= 11'(SPAWN_LIMIT))
            p = p - 11'(SPAWN_LIMIT);
        return p;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// game_lfsr
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Advances on every clock; intended as a shared pseudo-random source.
// Ports:
//   clk   in  1  : clock
//   reset in  1  : asynchronous active-low reset (loads SEED)
//   value out 16 : current LFSR state
// Parameters:
//   SEED : reset value, must be nonzero
module game_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] lfsr_reg;
    logic        feedback;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr_reg <= SEED;
        else
            lfsr_reg <= {lfsr_reg[14:0], feedback};
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/game_scheduler.sv
// game_scheduler
// Frame-synchronous controller: turns player buttons and the collision flag
// into one-cycle move/bullet/object_position commands, runs the IDLE/PLAY/OVER
// state machine and spawns enemies at pseudo-random x positions.
// Ports:
//   clk             in  1  : clock
//   reset           in  1  : asynchronous active-low reset
//   frame_start     in  1  : one-cycle pulse per frame
//   btn_left/right/fire/start in 1 : debounced button levels
//   hit             in  1  : collision level
//   move            out 2  : 0 right, 1 left, 2 hold
//   bullet          out 1  : one-cycle fire pulse
//   object_position out 11 : enemy x for one cycle, else 1000
//   score           out 16 : enemies spawned in the current game (saturating)
//   state           out 2  : 0 IDLE, 1 PLAY, 2 OVER
// Build option:
//   GAME_SCHED_AUTOFIRE_EN : when defined, holding fire re-fires every
//   FIRE_COOLDOWN frames; otherwise one bullet per press.
module game_scheduler
    import game_pkg::*;
#(
    parameter int          SPAWN_PERIOD  = 60,
    parameter int          FIRE_COOLDOWN = 20,
    parameter int          OVER_FRAMES   = 180,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    input  logic        btn_start,
    input  logic        hit,
    output logic [1:0]  move,
    output logic        bullet,
    output logic [10:0] object_position,
    output logic [15:0] score,
    output logic [1:0]  state
);

    logic [15:0] lfsr_value;

    game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    game_state_t state_reg;
    logic [1:0]  move_reg;
    logic        bullet_reg;
    logic [10:0] pos_reg;
    logic [15:0] score_reg;
    logic [15:0] spawn_cnt_reg;
    logic [7:0]  cooldown_reg;
    logic [7:0]  over_cnt_reg;
    logic        fire_latch_reg;
    logic        start_prev_reg;

    logic        start_rise;
    logic        fire_pending;
    logic [7:0]  cooldown_eff;
    logic        fire_now;
    logic        spawn_now;
    logic        over_done;

    assign start_rise = btn_start & ~start_prev_reg;

`ifdef GAME_SCHED_AUTOFIRE_EN
    assign fire_pending = fire_latch_reg;
`else
    logic fire_prev_reg;
    logic fire_rise;
    assign fire_rise    = btn_fire & ~fire_prev_reg;
    // Include a same-cycle press so a press on the frame_start cycle is not lost.
    assign fire_pending = fire_latch_reg | fire_rise;
`endif

    // The decrement for this frame is applied before the zero test, so bullets
    // are spaced exactly FIRE_COOLDOWN frames apart.
    assign cooldown_eff = (cooldown_reg == 8'd0) ? 8'd0 : cooldown_reg - 8'd1;
    assign fire_now     = fire_pending && (cooldown_eff == 8'd0);
    assign spawn_now    = (spawn_cnt_reg == 16'(SPAWN_PERIOD - 1));
    assign over_done    = (over_cnt_reg == 8'(OVER_FRAMES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            move_reg       <= MOVE_HOLD;
            bullet_reg     <= 1'b0;
            pos_reg        <= 11'(UNDEFINED_POSITION);
            score_reg      <= 16'd0;
            spawn_cnt_reg  <= 16'd0;
            cooldown_reg   <= 8'd0;
            over_cnt_reg   <= 8'd0;
            fire_latch_reg <= 1'b0;
            start_prev_reg <= 1'b0;
`ifndef GAME_SCHED_AUTOFIRE_EN
            fire_prev_reg  <= 1'b0;
`endif
        end else begin
            start_prev_reg <= btn_start;
`ifndef GAME_SCHED_AUTOFIRE_EN
            fire_prev_reg  <= btn_fire;
`endif
            // Commands are single-cycle: default back to idle values.
            move_reg   <= MOVE_HOLD;
            bullet_reg <= 1'b0;
            pos_reg    <= 11'(UNDEFINED_POSITION);

            case (state_reg)
                IDLE: begin
                    fire_latch_reg <= 1'b0;
                    cooldown_reg   <= 8'd0;
                    if (start_rise) begin
                        state_reg     <= PLAY;
                        score_reg     <= 16'd0;
                        spawn_cnt_reg <= 16'd0;
                    end
                end

                PLAY: begin
`ifdef GAME_SCHED_AUTOFIRE_EN
                    fire_latch_reg <= btn_fire;
`else
                    if (fire_rise)
                        fire_latch_reg <= 1'b1;
`endif
                    if (frame_start) begin
                        if (hit) begin
                            // Collision pre-empts every command this frame.
                            state_reg      <= OVER;
                            over_cnt_reg   <= 8'd0;
                            fire_latch_reg <= 1'b0;
                            cooldown_reg   <= 8'd0;
                        end else begin
                            if (btn_left && !btn_right)
                                move_reg <= MOVE_LEFT;
                            else if (btn_right && !btn_left)
                                move_reg <= MOVE_RIGHT;

                            if (fire_now) begin
                                bullet_reg   <= 1'b1;
                                cooldown_reg <= 8'(FIRE_COOLDOWN);
`ifndef GAME_SCHED_AUTOFIRE_EN
                                fire_latch_reg <= 1'b0;
`endif
                            end else begin
                                cooldown_reg <= cooldown_eff;
                            end

                            if (spawn_now) begin
                                spawn_cnt_reg <= 16'd0;
                                pos_reg       <= fold_position(lfsr_value);
                                if (score_reg != 16'hFFFF)
                                    score_reg <= score_reg + 16'd1;
                            end else begin
                                spawn_cnt_reg <= spawn_cnt_reg + 16'd1;
                            end
                        end
                    end
                end

                OVER: begin
                    fire_latch_reg <= 1'b0;
                    cooldown_reg   <= 8'd0;
                    if (start_rise) begin
                        state_reg <= IDLE;
                    end else if (frame_start) begin
                        if (over_done)
                            state_reg <= IDLE;
                        else
                            over_cnt_reg <= over_cnt_reg + 8'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign move            = move_reg;
    assign bullet          = bullet_reg;
    assign object_position = pos_reg;
    assign score           = score_reg;
    assign state           = state_reg;

endmodule

// File: tb/tb_game_scheduler.sv
// tb_game_scheduler
// Directed bench for game_scheduler with SPAWN_PERIOD=4, FIRE_COOLDOWN=3,
// OVER_FRAMES=3. Inputs change and outputs are sampled 1 time unit after
// the rising clock edge.
module tb_game_scheduler;

    localparam int          SP   = 4;
    localparam int          FC   = 3;
    localparam int          OF   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        btn_left, btn_right, btn_fire, btn_start;
    logic        hit;
    logic [1:0]  move;
    logic        bullet;
    logic [10:0] object_position;
    logic [15:0] score;
    logic [1:0]  state;

    game_scheduler #(
        .SPAWN_PERIOD  (SP),
        .FIRE_COOLDOWN (FC),
        .OVER_FRAMES   (OF),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_fire        (btn_fire),
        .btn_start       (btn_start),
        .hit             (hit),
        .move            (move),
        .bullet          (bullet),
        .object_position (object_position),
        .score           (score),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, advancing every clock.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset)
            m_lfsr <= SEED;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int vec    = 0;
    int errs   = 0;
    int sp_cnt = 0;
    int exp_score = 0;

    function automatic int ref_pos(input logic [15:0] v);
        int p;
        p = int'(v[9:0]);
        return (p >= 590) ? p - 590 : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_move"}, 32'(move), 32'd2);
        check({tag, "_bullet"}, 32'(bullet), 32'd0);
        check({tag, "_pos"}, 32'(object_position), 32'd1000);
    endtask

    // One PLAY frame: checks the command cycle and the quiet cycle after it.
    task automatic play_frame(input string tag, input int em, input int eb);
        logic spawn;
        int   ep;
        spawn = (sp_cnt == SP - 1);
        ep    = spawn ? ref_pos(m_lfsr) : 1000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (spawn) begin
            sp_cnt = 0;
            if (exp_score < 65535) exp_score++;
        end else begin
            sp_cnt++;
        end
        $display("frame %s: move=%0d bullet=%0d pos=%0d score=%0d", tag, move, bullet, object_position, score);
        check({tag, "_move"}, 32'(move), 32'(em));
        check({tag, "_bullet"}, 32'(bullet), 32'(eb));
        check({tag, "_pos"}, 32'(object_position), 32'(ep));
        if (spawn)
            check({tag, "_pos_range"}, 32'(object_position <= 11'd589), 32'd1);
        check({tag, "_score"}, 32'(score), 32'(exp_score));
        check({tag, "_state"}, 32'(state), 32'd1);
        tick();
        check_quiet({tag, "_after"});
    endtask

    initial begin
        reset = 1'b0; frame_start = 1'b0; hit = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; btn_start = 1'b0;

        // Reset values
        tick(); tick(); tick();
        check_quiet("rst");
        check("rst_score", 32'(score), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        reset = 1'b1;
        tick();

        // IDLE: frames produce no commands
        for (int i = 0; i < 5; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            $display("idle frame %0d: state=%0d move=%0d pos=%0d", i, state, move, object_position);
            check_quiet("idle_frame");
            check("idle_state", 32'(state), 32'd0);
            tick();
        end

        // Start -> PLAY without waiting for a frame
        btn_start = 1'b1;
        tick();
        check("start_state", 32'(state), 32'd1);
        check("start_score", 32'(score), 32'd0);
        sp_cnt = 0; exp_score = 0;
        btn_start = 1'b0;
        tick();

        // Spawns every 4th frame
        for (int i = 0; i < 12; i++) play_frame("spawn", 2, 0);
        check("spawn_score3", 32'(score), 32'd3);

        // Movement
        btn_left = 1'b1;
        for (int i = 0; i < 3; i++) play_frame("left", 1, 0);
        btn_right = 1'b1;
        play_frame("both", 2, 0);
        btn_left = 1'b0;
        play_frame("right", 0, 0);
        btn_right = 1'b0;
        play_frame("none", 2, 0);

        // Fire held for 10 frames
        btn_fire = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
`ifdef GAME_SCHED_AUTOFIRE_EN
            play_frame("fire", 2, (k % FC == 0) ? 1 : 0);
`else
            play_frame("fire", 2, (k == 0) ? 1 : 0);
`endif
        end
        btn_fire = 1'b0;
        for (int k = 0; k < 3; k++) play_frame("fire_rel", 2, 0);

        // Hit with a pending fire: OVER, no commands
        btn_fire = 1'b1;
        tick();
        hit = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        hit = 1'b0;
        btn_fire = 1'b0;
        $display("hit frame: state=%0d bullet=%0d", state, bullet);
        check("hit_state", 32'(state), 32'd2);
        check_quiet("hit");
        check("hit_score", 32'(score), 32'(exp_score));
        tick();

        // OVER times out after OF frames
        for (int i = 0; i < OF; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("over_state", 32'(state), (i < OF - 1) ? 32'd2 : 32'd0);
            check_quiet("over");
            tick();
        end

        // New game, hit, then btn_start leaves OVER early
        btn_start = 1'b1;
        tick();
        check("restart_state", 32'(state), 32'd1);
        check("restart_score", 32'(score), 32'd0);
        btn_start = 1'b0;
        sp_cnt = 0; exp_score = 0;
        tick();
        hit = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        hit = 1'b0;
        check("hit2_state", 32'(state), 32'd2);
        tick();
        btn_start = 1'b1;
        tick();
        check("over_start_state", 32'(state), 32'd0);
        btn_start = 1'b0;
        tick();

        // Asynchronous reset in the middle of PLAY
        btn_start = 1'b1;
        tick();
        check("play3_state", 32'(state), 32'd1);
        btn_start = 1'b0;
        sp_cnt = 0; exp_score = 0;
        btn_left = 1'b1;
        for (int i = 0; i < 4; i++) play_frame("prereset", 1, 0);
        frame_start = 1'b1;
        tick();
        check("mid_move", 32'(move), 32'd1);
        #2 reset = 1'b0;
        #1;
        $display("async reset: state=%0d move=%0d score=%0d", state, move, score);
        check_quiet("async_rst");
        check("async_rst_score", 32'(score), 32'd0);
        check("async_rst_state", 32'(state), 32'd0);
        frame_start = 1'b0;
        btn_left = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("post_rst_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
